// File: rtl/mem_pkg.sv
// Shared widths and controller state encoding for the two-port memory arbiter.
package mem_pkg;

  localparam int ADDR_W    = 4;
  localparam int DATA_W    = 4;
  localparam int NUM_WORDS = 16;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone eligible requester wins, a tie goes to the pointer.
module rr_arb2 (
  input  logic [1:0] eligible,
  input  logic       pointer,
  output logic [1:0] winner
);

  always_comb begin
    winner = eligible;
    if (eligible == 2'b11) begin
      winner = pointer ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a 16x4 RAM with optional post-reset clear sequence.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_INIT | clearing RAM, one word per cycle at ascending addresses
// ST_RUN  | arbitrating requests (ready=1 from the first edge in RUN on)
module mem_arbiter
  import mem_pkg::*;
#(
  parameter bit                INIT_EN    = 1'b1,
  parameter logic [DATA_W-1:0] INIT_VALUE = 4'h0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              ready,
  output logic              mem_load,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

  state_t            state;
  logic [ADDR_W-1:0] init_count;
  logic              pointer;
  logic [1:0]        eligible;
  logic [1:0]        winner;

  // A requester still showing req during its own issue cycle is the same access.
  assign eligible = {req1 & ~gnt1, req0 & ~gnt0} & {2{ready}};

  rr_arb2 u_rr_arb2 (
    .eligible (eligible),
    .pointer  (pointer),
    .winner   (winner)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= INIT_EN ? ST_INIT : ST_RUN;
      init_count <= '0;
      pointer    <= 1'b0;
      ready      <= 1'b0;
      mem_load   <= 1'b0;
      mem_addr   <= '0;
      mem_in     <= '0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      rvalid0    <= 1'b0;
      rvalid1    <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      // The edge ending a read issue cycle captures the RAM output.
      rvalid0 <= gnt0 & ~mem_load;
      rvalid1 <= gnt1 & ~mem_load;
      if (gnt0 && !mem_load) rdata0 <= mem_rdata;
      if (gnt1 && !mem_load) rdata1 <= mem_rdata;
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;

      if (state == ST_INIT) begin
        if (mem_load && mem_addr == LAST_ADDR) begin
          state    <= ST_RUN;
          ready    <= 1'b1;
          mem_load <= 1'b0;
        end else begin
          mem_load   <= 1'b1;
          mem_addr   <= init_count;
          mem_in     <= INIT_VALUE;
          init_count <= init_count + 1'b1;
        end
      end else begin
        ready    <= 1'b1;
        mem_load <= 1'b0;
        if (winner[0]) begin
          mem_addr <= addr0;
          mem_in   <= wdata0;
          mem_load <= we0;
          gnt0     <= 1'b1;
          pointer  <= 1'b1;
        end else if (winner[1]) begin
          mem_addr <= addr1;
          mem_in   <= wdata1;
          mem_load <= we1;
          gnt1     <= 1'b1;
          pointer  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter INIT_EN, default 1, meaning: 1 = clear all 16 words after reset, 0 = skip clear.
REQ-002 Parameter INIT_VALUE, default 4'h0, meaning: value written to every word during clear.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req0, req1  input  1 each  requester i has a pending access.
REQ-006 we0, we1  input  1 each  1 = write, 0 = read; held stable with req until gnt.
REQ-007 addr0, addr1  input  4 each  word address; held stable with req until gnt.
REQ-008 wdata0, wdata1  input  4 each  write data; held stable with req until gnt.
REQ-009 gnt0, gnt1  output  1 each  one-cycle pulse: requester i's access is issued this cycle.
REQ-010 rvalid0, rvalid1  output  1 each  one-cycle pulse: rdata_i holds read result.
REQ-011 rdata0, rdata1  output  4 each  read data, held until next read completes for that requester.
REQ-012 ready  output  1  controller in RUN state, accepting requests.
REQ-013 mem_load, mem_addr[3:0], mem_in[3:0]  output  drive the 16x4 RAM write-enable, address, data.
REQ-014 mem_rdata  input  4  RAM asynchronous read data for mem_addr.

Function
REQ-015 States: INIT, RUN; after reset state is INIT if INIT_EN=1, else RUN.
REQ-016 INIT: 4-bit counter 0..15; each cycle registers mem_load=1, mem_addr=count, mem_in=INIT_VALUE; exactly 16 writes, addresses ascending.
REQ-017 After address 15 is driven, next edge registers mem_load=0, ready=1, state RUN; ready never deasserts except by reset.
REQ-018 Requests are ignored (no gnt) while ready=0.
REQ-019 RUN: at each edge with ready=1, requester i is eligible iff req_i=1 and gnt_i=0 (prevents double-grant of a held request).
REQ-020 One eligible requester: it wins; both eligible: the one not granted most recently wins (round-robin); pointer after reset favours requester 0.
REQ-021 Winning edge registers mem_addr=addr_i, mem_in=wdata_i, mem_load=we_i, gnt_i=1 for exactly one cycle (issue cycle).
REQ-022 No winner: mem_load=0, gnt0=gnt1=0; mem_addr/mem_in hold previous values.
REQ-023 Write: RAM commits at the edge ending the issue cycle; latency req-sampled-edge to commit = 2 edges.
REQ-024 Read: mem_rdata captured at the edge ending the issue cycle into rdata_i, rvalid_i=1 for one cycle; no rvalid for writes.
REQ-025 Throughput: one access per cycle when both requesters alternate; single requester at most one access per 2 cycles.
REQ-026 Read issued the cycle after a write to the same address returns the newly written data.

Reset
REQ-027 While reset=1 at an edge: mem_load=0, mem_addr=0, mem_in=0, gnt0/1=0, rvalid0/1=0, rdata0/1=0, ready=0, init counter=0, RR pointer=requester 0.
REQ-028 Reset mid-INIT restarts clear at address 0; reset mid-access drops it (no commit, no gnt, no rvalid).
REQ-029 With INIT_EN=0, ready=1 at first edge after reset deasserts.

Structure
REQ-030 Shared package mem_pkg holds ADDR_W=4, DATA_W=4, NUM_WORDS=16 and the INIT/RUN state encoding.
REQ-031 2-way round-robin pick logic is a sub-module rr_arb2 (inputs eligible[1:0], pointer; output winner one-hot).

Verification
REQ-032 Reset release, INIT_EN=1, INIT_VALUE=4'hA -> mem_load high 16 cycles, addr 0..15, ready rises 17 edges after release; all words read 4'hA.
REQ-033 req0 write addr 3 data 4'h5, then req1 read addr 3 -> gnt0, next cycle gnt1, rdata1=4'h5 with rvalid1.
REQ-034 req0 and req1 held continuously reading addr 1 and 2 -> grants alternate 0,1,0,1; no gnt_i on consecutive cycles.
REQ-035 req0 only, held with new fields each gnt -> gnt0 every second cycle, never two consecutive.
REQ-036 Requests asserted during INIT -> no gnt until ready=1; first grant goes to requester 0.
REQ-037 Reset asserted during issue cycle of write 4'hF to addr 7 -> no rvalid, INIT restarts, addr 7 reads INIT_VALUE.
